// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared types, constants and dispatch address formation for ir_dispatch
package ir_pkg;

  localparam int DEF_A_W = 3;
  localparam int DEF_B_W = 3;
  localparam int DEF_J_W = 10;
  localparam logic [8:0] JRST_OP = 9'o254;

  typedef struct packed {
    logic [DEF_A_W-1:0] a;
    logic [DEF_B_W-1:0] b;
    logic [DEF_J_W-1:0] j;
    logic               par;
  } dispatch_word_t;

  typedef enum logic [1:0] {
    DIAG_IDLE,
    DIAG_STAGE,
    DIAG_COMMIT
  } diag_state_e;

  // ir13[12] is instruction bit 0; 7xx opcodes fold into the I/O dispatch page.
  function automatic logic [8:0] dispatch_addr(input logic [12:0] ir13, input logic en_io_jrst);
    logic io;
    io = en_io_jrst & (&ir13[12:10]);
    if (io) dispatch_addr = {3'b111, ir13[5:3] | {3{&ir13[9:6]}}, ir13[2:0]};
    else    dispatch_addr = ir13[12:4];
  endfunction

endpackage

// File: rtl/dispatch_ram.sv
// rtl/dispatch_ram.sv - dispatch RAM wrapper selecting the simulation or target memory
module dispatch_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

`ifdef KL10PV_TB
  sim_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
`else
  dram_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
`endif

endmodule

// File: rtl/dram_mem.sv
// rtl/dram_mem.sv - single-port synchronous RAM with registered, resettable read data
module dram_mem #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sim_mem.sv
// rtl/sim_mem.sv - behavioural stand-in for the dispatch RAM used in system-level benches
`ifdef KL10PV_TB
module sim_mem #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`endif

// File: rtl/ir_dispatch.sv
// rtl/ir_dispatch.sv - instruction register, dispatch lookup with parity, diagnostic RAM writer
module ir_dispatch
  import ir_pkg::*;
#(
  parameter int IR_W       = 13,
  parameter int DRAM_DEPTH = 512,
  parameter int A_W        = 3,
  parameter int B_W        = 3,
  parameter int J_W        = 10,
  parameter int WORD_W     = A_W + B_W + J_W + 1,
  parameter int ADDR_W     = $clog2(DRAM_DEPTH),
  parameter int DD_W       = ((A_W + B_W + 1) > J_W) ? (A_W + B_W + 1) : J_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_ir,
  input  logic              mb_xfer,
  input  logic [IR_W-1:0]   ad_in,
  input  logic [IR_W-1:0]   cache_in,
  input  logic              en_ac,
  input  logic              en_io_jrst,
  input  logic              load_dram,
  output logic [IR_W-1:0]   ir,
  output logic [3:0]        irac,
  output logic [A_W-1:0]    dram_a,
  output logic [B_W-1:0]    dram_b,
  output logic [J_W-1:0]    dram_j,
  output logic              dram_valid,
  output logic              dram_par_err,
  input  logic              diag_we,
  input  logic              diag_sel,
  input  logic [ADDR_W-1:0] diag_addr,
  input  logic [DD_W-1:0]   diag_data,
  input  logic              diag_abort,
  input  logic              diag_clr_err,
  output logic              diag_busy,
  output logic              diag_ack,
  output logic [ADDR_W-1:0] dradr
);

  localparam int AB_W = A_W + B_W + 1;

  diag_state_e       state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [3:0]        irac_q, irac_d;
  logic [ADDR_W-1:0] dradr_q, dradr_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic              has_ab_q, has_ab_d;
  logic              has_j_q, has_j_d;
  logic [AB_W-1:0]   stg_ab_q, stg_ab_d;
  logic [J_W-1:0]    stg_j_q, stg_j_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;

  logic              idle, start, ram_we, fresh_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic [J_W-1:0]    ram_j;
  logic [12:0]       ir13;

  assign ir13  = ir_q[IR_W-1 -: 13];
  assign idle  = (state_q == DIAG_IDLE);
  // A lookup only owns the RAM port while the writer is idle; a blocked request waits in pend_q.
  assign start = idle & (load_dram | pend_q);

  always_comb begin
    ir_d   = ir_q;
    irac_d = irac_q;
    if (load_ir) begin
      ir_d   = mb_xfer ? ad_in : cache_in;
      irac_d = en_ac ? ir_d[IR_W-10 -: 4] : 4'b0;
    end
    dradr_d = start ? ADDR_W'(dispatch_addr(ir13, en_io_jrst)) : dradr_q;
    rd_d    = start;
    done_d  = rd_q;
    pend_d  = idle ? 1'b0 : (pend_q | load_dram);
    valid_d = valid_q;
    if (load_ir || start) valid_d = 1'b0;
    else if (rd_q)        valid_d = 1'b1;
    err_d = (err_q & ~diag_clr_err) | fresh_err;
  end

  always_comb begin
    state_d  = state_q;
    has_ab_d = has_ab_q;
    has_j_d  = has_j_q;
    stg_ab_d = stg_ab_q;
    stg_j_d  = stg_j_q;
    waddr_d  = waddr_q;
    ram_we   = 1'b0;
    unique case (state_q)
      DIAG_IDLE, DIAG_STAGE: begin
        if (state_q == DIAG_STAGE && diag_abort) begin
          state_d  = DIAG_IDLE;
          has_ab_d = 1'b0;
          has_j_d  = 1'b0;
        end else if (diag_we) begin
          waddr_d = diag_addr;
          if (diag_sel) begin
            stg_j_d = diag_data[J_W-1:0];
            has_j_d = 1'b1;
          end else begin
            stg_ab_d = diag_data[AB_W-1:0];
            has_ab_d = 1'b1;
          end
          state_d = (has_ab_d && has_j_d) ? DIAG_COMMIT : DIAG_STAGE;
        end
      end
      DIAG_COMMIT: begin
        ram_we   = 1'b1;
        has_ab_d = 1'b0;
        has_j_d  = 1'b0;
        state_d  = DIAG_IDLE;
      end
      default: state_d = DIAG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIAG_IDLE;
      ir_q     <= '0;
      irac_q   <= '0;
      dradr_q  <= '0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      has_ab_q <= 1'b0;
      has_j_q  <= 1'b0;
      stg_ab_q <= '0;
      stg_j_q  <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      irac_q   <= irac_d;
      dradr_q  <= dradr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      has_ab_q <= has_ab_d;
      has_j_q  <= has_j_d;
      stg_ab_q <= stg_ab_d;
      stg_j_q  <= stg_j_d;
      waddr_q  <= waddr_d;
    end
  end

  // Stored word layout is {A, B, J, P}; the A/B half carries P in its LSB.
  assign ram_wdata = {stg_ab_q[AB_W-1:1], stg_j_q, stg_ab_q[0]};
  assign ram_addr  = ram_we ? waddr_q : dradr_q;

  dispatch_ram #(.DEPTH(DRAM_DEPTH), .AW(ADDR_W), .DW(WORD_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (rd_q),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign fresh_err = done_q & ~(^ram_rdata);
  assign ram_j     = ram_rdata[J_W:1];

  assign ir           = ir_q;
  assign irac         = irac_q;
  assign dram_a       = ram_rdata[WORD_W-1 -: A_W];
  assign dram_b       = ram_rdata[WORD_W-1-A_W -: B_W];
  assign dram_j       = (ir13[12:4] == JRST_OP) ? {ram_j[J_W-1:4], ir13[3:0]} : ram_j;
  assign dram_valid   = valid_q;
  assign dram_par_err = err_q | fresh_err;
  assign diag_busy    = ~idle;
  assign diag_ack     = (state_q == DIAG_COMMIT);
  assign dradr        = dradr_q;

endmodule

// File: tb/tb_ir_dispatch.sv
// tb/tb_ir_dispatch.sv - self-checking bench for ir_dispatch against a behavioural dispatch model
module tb_ir_dispatch;

  logic        clk = 1'b0;
  logic        rst_n, load_ir, mb_xfer, en_ac, en_io_jrst, load_dram;
  logic [12:0] ad_in, cache_in, ir;
  logic [3:0]  irac;
  logic [2:0]  dram_a, dram_b;
  logic [9:0]  dram_j;
  logic        dram_valid, dram_par_err, diag_we, diag_sel, diag_abort, diag_clr_err;
  logic        diag_busy, diag_ack;
  logic [8:0]  diag_addr, dradr;
  logic [9:0]  diag_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int m_a [512];
  int m_b [512];
  int m_j [512];
  int m_p [512];
  int ir_m    = 0;
  int dradr_m = 0;
  bit err_m   = 1'b0;

  ir_dispatch dut (
    .clk(clk), .rst_n(rst_n), .load_ir(load_ir), .mb_xfer(mb_xfer), .ad_in(ad_in),
    .cache_in(cache_in), .en_ac(en_ac), .en_io_jrst(en_io_jrst), .load_dram(load_dram),
    .ir(ir), .irac(irac), .dram_a(dram_a), .dram_b(dram_b), .dram_j(dram_j),
    .dram_valid(dram_valid), .dram_par_err(dram_par_err), .diag_we(diag_we),
    .diag_sel(diag_sel), .diag_addr(diag_addr), .diag_data(diag_data),
    .diag_abort(diag_abort), .diag_clr_err(diag_clr_err), .diag_busy(diag_busy),
    .diag_ack(diag_ack), .dradr(dradr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int op, input int ac, input bit io_en);
    int mid;
    if (io_en && op >= 'o700) begin
      mid = ((op & 3) << 1) | (ac >> 3);
      if (((op >> 2) & 'hF) == 'hF) mid = 7;
      return 'o700 | (mid << 3) | (ac & 7);
    end
    return op;
  endfunction

  function automatic int good_par(input int a, input int b, input int j);
    return ($countones({3'(a), 3'(b), 10'(j)}) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic diag_write(input bit sel, input int addr, input int data);
    diag_we   = 1'b1;
    diag_sel  = sel;
    diag_addr = 9'(addr);
    diag_data = 10'(data);
    cyc();
    diag_we = 1'b0;
  endtask

  task automatic write_word(input int addr, input int a, input int b, input int j, input int p,
                            input int mode);
    int ab;
    ab = (a << 4) | (b << 1) | p;
    if (mode == 3) begin
      diag_write(1'b0, $urandom_range(0, 511), $urandom_range(0, 127));
      diag_abort = 1'b1;
      cyc();
      diag_abort = 1'b0;
      check("abort_idle", 32'(diag_busy), 0);
    end
    if (mode == 1) begin
      diag_write(1'b1, addr, j);
      diag_write(1'b0, addr, ab);
    end else begin
      if (mode == 2) diag_write(1'b0, $urandom_range(0, 511), $urandom_range(0, 127));
      diag_write(1'b0, addr, ab);
      diag_write(1'b1, addr, j);
    end
    check("ack_pulse", 32'(diag_ack), 1);
    cyc();
    check("ack_end", 32'(diag_ack), 0);
    check("busy_end", 32'(diag_busy), 0);
    m_a[addr] = a;
    m_b[addr] = b;
    m_j[addr] = j;
    m_p[addr] = p;
  endtask

  task automatic set_ir(input int v, input bit mbx, input bit eac);
    mb_xfer = mbx;
    en_ac   = eac;
    if (mbx) begin
      ad_in    = 13'(v);
      cache_in = 13'($urandom);
    end else begin
      cache_in = 13'(v);
      ad_in    = 13'($urandom);
    end
    load_ir = 1'b1;
    cyc();
    load_ir = 1'b0;
    ir_m = v & 'h1FFF;
    check("ir", 32'(ir), ir_m);
    check("irac", 32'(irac), eac ? (ir_m & 15) : 0);
    check("valid_clr", 32'(dram_valid), 0);
  endtask

  task automatic expect_data(input string tag, input int ea);
    int ej;
    ej = m_j[ea];
    if ((ir_m >> 4) == 'o254) ej = (ej & ~15) | (ir_m & 15);
    if ($countones({3'(m_a[ea]), 3'(m_b[ea]), 10'(m_j[ea]), 1'(m_p[ea])}) % 2 == 0) err_m = 1'b1;
    check({tag, "_a"}, 32'(dram_a), m_a[ea]);
    check({tag, "_b"}, 32'(dram_b), m_b[ea]);
    check({tag, "_j"}, 32'(dram_j), ej);
    check({tag, "_valid"}, 32'(dram_valid), 1);
    check({tag, "_perr"}, 32'(dram_par_err), 32'(err_m));
  endtask

  task automatic lookup_check(input string tag);
    int ea;
    ea = exp_addr(ir_m >> 4, ir_m & 15, en_io_jrst);
    load_dram = 1'b1;
    cyc();
    load_dram = 1'b0;
    check({tag, "_dradr"}, 32'(dradr), ea);
    check({tag, "_valid_lo"}, 32'(dram_valid), 0);
    cyc();
    expect_data(tag, ea);
    dradr_m = ea;
  endtask

  task automatic clr_err();
    cyc();
    diag_clr_err = 1'b1;
    cyc();
    diag_clr_err = 1'b0;
    err_m = 1'b0;
    check("perr_clr", 32'(dram_par_err), 0);
  endtask

  initial begin
    rst_n = 1'b0; load_ir = 1'b0; mb_xfer = 1'b0; en_ac = 1'b0; en_io_jrst = 1'b0;
    load_dram = 1'b0; ad_in = '0; cache_in = '0; diag_we = 1'b0; diag_sel = 1'b0;
    diag_addr = '0; diag_data = '0; diag_abort = 1'b0; diag_clr_err = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    check("rst_ir", 32'(ir), 0);
    check("rst_irac", 32'(irac), 0);
    check("rst_a", 32'(dram_a), 0);
    check("rst_b", 32'(dram_b), 0);
    check("rst_j", 32'(dram_j), 0);
    check("rst_valid", 32'(dram_valid), 0);
    check("rst_perr", 32'(dram_par_err), 0);
    check("rst_busy", 32'(diag_busy), 0);
    check("rst_ack", 32'(diag_ack), 0);
    check("rst_dradr", 32'(dradr), 0);

    write_word('o270, 3, 5, 'o123, good_par(3, 5, 'o123), 0);
    set_ir('o270 << 4, 1'b0, 1'b1);
    lookup_check("d270");

    write_word('o254, 1, 2, 'o1760, good_par(1, 2, 'o1760), 1);
    set_ir(('o254 << 4) | 'b1010, 1'b1, 1'b0);
    lookup_check("jrst");

    write_word('o773, 6, 1, 'o55, good_par(6, 1, 'o55), 0);
    write_word('o777, 2, 7, 'o1001, good_par(2, 7, 'o1001), 0);
    en_io_jrst = 1'b1;
    set_ir(('o777 << 4) | 'b0011, 1'b0, 1'b1);
    lookup_check("io_on");
    check("io_on_const", 32'(dradr), 'o773);
    en_io_jrst = 1'b0;
    set_ir(('o777 << 4) | 'b0011, 1'b0, 1'b1);
    lookup_check("io_off");
    check("io_off_const", 32'(dradr), 'o777);

    write_word('o100, 4, 4, 'o17, 1 - good_par(4, 4, 'o17), 2);
    set_ir('o100 << 4, 1'b0, 1'b0);
    lookup_check("par_bad");
    check("par_bad_set", 32'(dram_par_err), 1);
    set_ir('o270 << 4, 1'b1, 1'b0);
    lookup_check("par_sticky");
    check("par_sticky_set", 32'(dram_par_err), 1);
    clr_err();

    set_ir('o345 << 4, 1'b0, 1'b0);
    diag_write(1'b0, 'o345, (5 << 4) | (2 << 1) | good_par(5, 2, 'o606));
    check("pend_busy", 32'(diag_busy), 1);
    load_dram = 1'b1;
    cyc();
    load_dram = 1'b0;
    cyc();
    cyc();
    check("pend_no_valid", 32'(dram_valid), 0);
    check("pend_no_dradr", 32'(dradr), dradr_m);
    diag_write(1'b1, 'o345, 'o606);
    check("pend_ack", 32'(diag_ack), 1);
    m_a['o345] = 5; m_b['o345] = 2; m_j['o345] = 'o606; m_p['o345] = good_par(5, 2, 'o606);
    cyc();
    check("pend_ack_end", 32'(diag_ack), 0);
    check("pend_start_dradr", 32'(dradr), dradr_m);
    cyc();
    check("pend_dradr", 32'(dradr), 'o345);
    check("pend_valid_lo", 32'(dram_valid), 0);
    cyc();
    expect_data("pend", 'o345);
    dradr_m = 'o345;

    for (int i = 0; i < 40; i++) begin
      int op, ac, a, b, j, p, ea, r;
      bit io;
      r  = $urandom_range(0, 3);
      op = (r == 0) ? 'o254 : (r == 1) ? ('o700 + $urandom_range(0, 63)) : $urandom_range(0, 511);
      ac = $urandom_range(0, 15);
      io = 1'($urandom_range(0, 1));
      en_io_jrst = io;
      ea = exp_addr(op, ac, io);
      a  = $urandom_range(0, 7);
      b  = $urandom_range(0, 7);
      j  = $urandom_range(0, 1023);
      p  = good_par(a, b, j);
      if ($urandom_range(0, 7) == 0) p = 1 - p;
      write_word(ea, a, b, j, p, $urandom_range(0, 3));
      set_ir((op << 4) | ac, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      lookup_check("rnd");
      if ($urandom_range(0, 3) == 0) clr_err();
    end

    diag_write(1'b0, 'o12, 'h55);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("midrst_busy", 32'(diag_busy), 0);
    check("midrst_valid", 32'(dram_valid), 0);
    check("midrst_ir", 32'(ir), 0);
    check("midrst_perr", 32'(dram_par_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
